// File: rtl/contador_progressivo_mmss.sv
// contador_progressivo_mmss: up-counting BCD stopwatch, MM:SS from 00:00 up to
// MAX_MINUTOS:59. It advances on the shared 1 Hz tick strobe and stops in an
// overflow state at the ceiling instead of wrapping around.
module contador_progressivo_mmss #(
    parameter int MAX_MINUTOS = 99
) (
    input  logic       clk,
    input  logic       clearN,
    input  logic       tick,
    input  logic       iniciar,
    input  logic       pausar,
    input  logic       zerar,
    output logic [3:0] qUnidadeSegundos,
    output logic [3:0] qDezenaSegundos,
    output logic [3:0] qUnidadeMinutos,
    output logic [3:0] qDezenaMinutos,
    output logic       carryMinuto,
    output logic       contando,
    output logic       estouro
);

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        CONTANDO = 2'd1,
        ESTOURO  = 2'd2
    } estado_t;

    // Ceiling split into BCD minute digits so the comparison is per-digit.
    localparam logic [3:0] MAX_MT = 4'(MAX_MINUTOS / 10);
    localparam logic [3:0] MAX_MU = 4'(MAX_MINUTOS % 10);

    estado_t    estado_q, estado_d;
    logic [3:0] su_q, su_d;
    logic [3:0] st_q, st_d;
    logic [3:0] mu_q, mu_d;
    logic [3:0] mt_q, mt_d;
    logic       carry_q, carry_d;
    logic       contando_q, contando_d;
    logic       estouro_q, estouro_d;

    logic cmd_clear;
    logic cmd_pause;
    logic cmd_start;
    logic cmd_tick;
    logic at_max;

    // Command decode: at most one command is honoured per cycle, highest
    // priority first (zerar, pausar, iniciar, tick).
    always_comb begin
        cmd_clear = zerar;
        cmd_pause = !zerar && pausar;
        cmd_start = !zerar && !pausar && iniciar;
        cmd_tick  = !zerar && !pausar && !iniciar && tick;
    end

    // True when the display already shows MAX_MINUTOS:59.
    always_comb begin
        at_max = (mt_q == MAX_MT) && (mu_q == MAX_MU) &&
                 (st_q == 4'd5)   && (su_q == 4'd9);
    end

    // Next-state logic for the control FSM.
    always_comb begin
        estado_d = estado_q;
        if (cmd_clear) begin
            estado_d = PARADO;
        end else begin
            case (estado_q)
                PARADO: begin
                    if (cmd_start) begin
                        estado_d = CONTANDO;
                    end
                end
                CONTANDO: begin
                    if (cmd_pause) begin
                        estado_d = PARADO;
                    end else if (cmd_tick && at_max) begin
                        estado_d = ESTOURO;
                    end
                end
                ESTOURO: begin
                    estado_d = ESTOURO;
                end
                default: begin
                    estado_d = PARADO;
                end
            endcase
        end
        contando_d = (estado_d == CONTANDO);
        estouro_d  = (estado_d == ESTOURO);
    end

    // Digit datapath: clear, or a full BCD ripple increment on a counted tick.
    // At the ceiling the digits hold and no minute carry is produced.
    always_comb begin
        su_d    = su_q;
        st_d    = st_q;
        mu_d    = mu_q;
        mt_d    = mt_q;
        carry_d = 1'b0;
        if (cmd_clear) begin
            su_d = 4'd0;
            st_d = 4'd0;
            mu_d = 4'd0;
            mt_d = 4'd0;
        end else if ((estado_q == CONTANDO) && cmd_tick && !at_max) begin
            if (su_q == 4'd9) begin
                su_d = 4'd0;
                if (st_q == 4'd5) begin
                    st_d    = 4'd0;
                    carry_d = 1'b1;
                    if (mu_q == 4'd9) begin
                        mu_d = 4'd0;
                        mt_d = mt_q + 4'd1;
                    end else begin
                        mu_d = mu_q + 4'd1;
                    end
                end else begin
                    st_d = st_q + 4'd1;
                end
            end else begin
                su_d = su_q + 4'd1;
            end
        end
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge clearN) begin
        if (!clearN) begin
            estado_q   <= PARADO;
            su_q       <= 4'd0;
            st_q       <= 4'd0;
            mu_q       <= 4'd0;
            mt_q       <= 4'd0;
            carry_q    <= 1'b0;
            contando_q <= 1'b0;
            estouro_q  <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            su_q       <= su_d;
            st_q       <= st_d;
            mu_q       <= mu_d;
            mt_q       <= mt_d;
            carry_q    <= carry_d;
            contando_q <= contando_d;
            estouro_q  <= estouro_d;
        end
    end

    assign qUnidadeSegundos = su_q;
    assign qDezenaSegundos  = st_q;
    assign qUnidadeMinutos  = mu_q;
    assign qDezenaMinutos   = mt_q;
    assign carryMinuto      = carry_q;
    assign contando         = contando_q;
    assign estouro          = estouro_q;

endmodule

// File: tb/tb_contador_progressivo_mmss.sv
// Testbench for contador_progressivo_mmss: two instances (default ceiling 99
// and ceiling 2) driven by directed steps; expected values come from a
// seconds-based model and travel through a scoreboard queue.
module tb_contador_progressivo_mmss;

    logic       clk = 1'b0;
    logic       clearN;
    logic       tick_v    [2];
    logic       iniciar_v [2];
    logic       pausar_v  [2];
    logic       zerar_v   [2];
    logic [3:0] su_o      [2];
    logic [3:0] st_o      [2];
    logic [3:0] mu_o      [2];
    logic [3:0] mt_o      [2];
    logic       carry_o   [2];
    logic       cont_o    [2];
    logic       est_o     [2];

    always #5 clk = ~clk;

    contador_progressivo_mmss u_dut99 (
        .clk              (clk),
        .clearN           (clearN),
        .tick             (tick_v[0]),
        .iniciar          (iniciar_v[0]),
        .pausar           (pausar_v[0]),
        .zerar            (zerar_v[0]),
        .qUnidadeSegundos (su_o[0]),
        .qDezenaSegundos  (st_o[0]),
        .qUnidadeMinutos  (mu_o[0]),
        .qDezenaMinutos   (mt_o[0]),
        .carryMinuto      (carry_o[0]),
        .contando         (cont_o[0]),
        .estouro          (est_o[0])
    );

    contador_progressivo_mmss #(.MAX_MINUTOS(2)) u_dut2 (
        .clk              (clk),
        .clearN           (clearN),
        .tick             (tick_v[1]),
        .iniciar          (iniciar_v[1]),
        .pausar           (pausar_v[1]),
        .zerar            (zerar_v[1]),
        .qUnidadeSegundos (su_o[1]),
        .qDezenaSegundos  (st_o[1]),
        .qUnidadeMinutos  (mu_o[1]),
        .qDezenaMinutos   (mt_o[1]),
        .carryMinuto      (carry_o[1]),
        .contando         (cont_o[1]),
        .estouro          (est_o[1])
    );

    typedef struct {
        int          idx;
        string       tag;
        logic [18:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: elapsed seconds and a state code (0 stop, 1 run, 2 overflow).
    int   secs    [2];
    int   stm     [2];
    int   maxm    [2] = '{99, 2};
    logic carry_m [2];

    function automatic logic [18:0] model_vec(int k);
        int m;
        int s;
        logic [3:0] dmt, dmu, dst, dsu;
        m   = secs[k] / 60;
        s   = secs[k] % 60;
        dmt = 4'(m / 10);
        dmu = 4'(m % 10);
        dst = 4'(s / 10);
        dsu = 4'(s % 10);
        return {dmt, dmu, dst, dsu, carry_m[k], stm[k] == 1, stm[k] == 2};
    endfunction

    function automatic logic [18:0] obs_vec(int k);
        return {mt_o[k], mu_o[k], st_o[k], su_o[k], carry_o[k], cont_o[k], est_o[k]};
    endfunction

    function automatic void model_update(int k, bit z, bit p, bit i, bit t);
        carry_m[k] = 1'b0;
        if (z) begin
            secs[k] = 0;
            stm[k]  = 0;
        end else if (stm[k] == 0) begin
            if (!p && i) stm[k] = 1;
        end else if (stm[k] == 1) begin
            if (p) begin
                stm[k] = 0;
            end else if (!i && t) begin
                if (secs[k] == maxm[k] * 60 + 59) begin
                    stm[k] = 2;
                end else begin
                    secs[k]    = secs[k] + 1;
                    carry_m[k] = (secs[k] % 60 == 0);
                end
            end
        end
    endfunction

    task automatic compare_front();
        exp_t        e;
        logic [18:0] o;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e = sb.pop_front();
            o = obs_vec(e.idx);
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s dut%0d observed=%h expected=%h (mt mu st su carry cont est)",
                       e.tag, e.idx, o, e.val);
            end
        end
    endtask

    task automatic step(int k, bit z, bit p, bit i, bit t, string tag);
        exp_t e;
        @(negedge clk);
        zerar_v[k]   = z;
        pausar_v[k]  = p;
        iniciar_v[k] = i;
        tick_v[k]    = t;
        model_update(k, z, p, i, t);
        e.idx = k;
        e.tag = tag;
        e.val = model_vec(k);
        sb.push_back(e);
        @(posedge clk);
        #1;
        zerar_v[k]   = 1'b0;
        pausar_v[k]  = 1'b0;
        iniciar_v[k] = 1'b0;
        tick_v[k]    = 1'b0;
        compare_front();
        $display("step dut%0d %s -> %0d%0d:%0d%0d carry=%0b cont=%0b est=%0b",
                 k, tag, mt_o[k], mu_o[k], st_o[k], su_o[k], carry_o[k], cont_o[k], est_o[k]);
    endtask

    task automatic ticks(int k, int n, string tag);
        for (int j = 0; j < n; j++) step(k, 0, 0, 0, 1, tag);
    endtask

    task automatic check_now(int k, string tag);
        exp_t e;
        e.idx = k;
        e.tag = tag;
        e.val = model_vec(k);
        sb.push_back(e);
        compare_front();
        $display("check dut%0d %s -> %0d%0d:%0d%0d carry=%0b cont=%0b est=%0b",
                 k, tag, mt_o[k], mu_o[k], st_o[k], su_o[k], carry_o[k], cont_o[k], est_o[k]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            secs[k]    = 0;
            stm[k]     = 0;
            carry_m[k] = 1'b0;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            tick_v[k]    = 1'b0;
            iniciar_v[k] = 1'b0;
            pausar_v[k]  = 1'b0;
            zerar_v[k]   = 1'b0;
        end
        model_reset();
        clearN = 1'b1;
        #2;
        clearN = 1'b0;
        #20;
        check_now(0, "reset");
        check_now(1, "reset");
        @(negedge clk);
        clearN = 1'b1;

        // Reset, start, 61 ticks -> 01:01 with one minute carry
        step(0, 0, 0, 0, 1, "parado_tick_ignored");
        step(0, 0, 0, 1, 0, "iniciar");
        ticks(0, 61, "count_61");
        step(0, 0, 0, 1, 0, "iniciar_noop_running");
        // Up to 09:59 then the four-digit rollover
        ticks(0, 538, "to_0959");
        step(0, 0, 0, 0, 1, "rollover_1000");
        step(0, 0, 0, 0, 0, "carry_drops");

        // Pause with a same-cycle tick at 00:30
        step(0, 1, 0, 0, 0, "zerar");
        step(0, 0, 0, 1, 1, "iniciar_with_tick");
        ticks(0, 30, "to_0030");
        step(0, 0, 1, 0, 1, "pausar_with_tick");
        ticks(0, 3, "paused_ticks");
        step(0, 0, 0, 1, 0, "resume");
        ticks(0, 5, "to_0035");

        // All commands at once at 05:17
        step(0, 1, 0, 0, 0, "zerar");
        step(0, 0, 0, 1, 0, "iniciar");
        ticks(0, 317, "to_0517");
        step(0, 1, 1, 1, 1, "all_commands");

        // Ceiling 2: overflow and hold
        step(1, 0, 0, 1, 0, "iniciar");
        ticks(1, 179, "to_0259");
        step(1, 0, 0, 0, 1, "overflow_tick");
        step(1, 0, 0, 0, 1, "estouro_tick");
        step(1, 0, 0, 1, 0, "estouro_iniciar");
        step(1, 0, 1, 0, 0, "estouro_pausar");
        step(1, 1, 0, 0, 1, "estouro_zerar");
        step(1, 0, 0, 1, 0, "restart");
        ticks(1, 2, "after_restart");

        // Asynchronous clear between edges at 03:42
        step(0, 0, 0, 1, 0, "iniciar");
        ticks(0, 222, "to_0342");
        @(negedge clk);
        #1;
        clearN = 1'b0;
        #1;
        model_reset();
        check_now(0, "async_clear");
        check_now(1, "async_clear");
        #1;
        clearN = 1'b1;
        ticks(0, 3, "after_clear_ticks");
        step(0, 0, 0, 1, 0, "iniciar_after_clear");
        ticks(0, 2, "count_after_clear");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/contador_progressivo_mmss.md
# contador_progressivo_mmss

Up-counting BCD stopwatch core, MM:SS from 00:00 to a configurable ceiling. It is the counting-up counterpart of the countdown digit counters: those preset and decrement toward a zero flag, while this block clears and increments toward an overflow flag. It sits beside them in the timer datapath, driven by the shared 1 Hz tick, and feeds the same 7-segment decoders digit-for-digit.

## Interface
- `MAX_MINUTOS`, 99: highest minute value reached, decimal 1..99; the ceiling is `MAX_MINUTOS`:59.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clearN`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle 1 Hz enable strobe.
- `iniciar`  in  1  start/resume pulse.
- `pausar`  in  1  pause pulse.
- `zerar`  in  1  synchronous clear to 00:00 and PARADO.
- `qUnidadeSegundos`  out  4  BCD seconds units, 0..9.
- `qDezenaSegundos`  out  4  BCD seconds tens, 0..5.
- `qUnidadeMinutos`  out  4  BCD minutes units, 0..9.
- `qDezenaMinutos`  out  4  BCD minutes tens, 0..9.
- `carryMinuto`  out  1  one-cycle pulse on each seconds wrap from 59 to 00.
- `contando`  out  1  high in CONTANDO.
- `estouro`  out  1  high in ESTOURO.

## Operation
- States: PARADO, CONTANDO, ESTOURO. `contando` and `estouro` decode the state directly and are registered.
- Command priority each cycle: `zerar` > `pausar` > `iniciar` > `tick`.
- `zerar` (any state): digits go to 0 and the state goes to PARADO. A same-cycle tick is discarded.
- PARADO:
  - `iniciar` moves to CONTANDO. A same-cycle tick is not applied.
  - `tick` alone is ignored.
- CONTANDO:
  - `pausar` moves to PARADO and discards a same-cycle tick.
  - `tick` increments MM:SS by one second.
  - `iniciar` is a no-op.
- Increment rules, applied as a BCD ripple within one edge:
  - su 9→0 carries into st.
  - st 5→0 carries into mu and pulses `carryMinuto`.
  - mu 9→0 carries into mt.
- When the value equals `MAX_MINUTOS`:59 and a tick is applied:
  - Digits hold at `MAX_MINUTOS`:59 (no wrap to 00:00).
  - The state goes to ESTOURO.
  - No `carryMinuto` pulse is issued.
- ESTOURO:
  - `tick`, `iniciar` and `pausar` are ignored.
  - Only `zerar` or `clearN` leaves ESTOURO.
- Digits never take non-BCD values or seconds tens above 5. No load path exists, so illegal codes are unreachable.

## Timing
- Reset (`clearN` = 0, asynchronous): all digits 0, state PARADO, `carryMinuto` = 0, `contando` = 0, `estouro` = 0. Reset applies immediately, mid-count included. Release is synchronous to the next edge.
- Latency: digits update on the same edge that samples `tick` = 1. `carryMinuto` is high for exactly the cycle following that edge.
- `iniciar` sampled at edge N gives `contando` = 1 after edge N. The first counted tick is the one sampled at edge N+1 or later.
- Back-to-back ticks on consecutive cycles are each counted; there is no rate limit.
- Outputs are all registered; no combinational path runs from inputs to outputs.

## Test plan
- Reset, then `iniciar`, then 61 ticks → 01:01. `carryMinuto` pulses once, after tick 60 (00:59→01:00).
- From 09:59 in CONTANDO, one tick → 10:00, all four digits change on one edge, and `carryMinuto` = 1 for one cycle.
- `MAX_MINUTOS` = 2: count to 02:59, apply one more tick → digits hold 02:59, `estouro` = 1, `contando` = 0. Further ticks and `iniciar` leave the state unchanged. `zerar` → 00:00 in PARADO.
- At 00:30 in CONTANDO, assert `pausar` with `tick` on the same cycle → 00:30 held and PARADO. Later `iniciar` and 5 ticks → 00:35.
- Simultaneous `zerar`, `pausar`, `iniciar` and `tick` at 05:17 → 00:00 in PARADO.
- Pulse `clearN` low between clock edges at 03:42 in CONTANDO → outputs go to 0 asynchronously and remain there until `iniciar`.
